scd_sc_fe: RTL and testbench
============================

Name: scd_sc_fe

Overview:
- Shift-count (SC) and floating-exponent (FE) register pair in the SCD.
- Sits directly upstream of the shift matrix. It supplies the registered SC value and the two range flags that select shift-inhibit in the SH mux, sc_ge_36 and sc_36_to_63.
- Also runs microcode step loops by counting SC down to negative, as used for multiply, divide and normalize iterations.

Parameters:
- W, 10, SC/FE width. Bit 0 is the MSB and the sign; bits 0:9 use big-endian numbering.
- MAX_STEP, 511, maximum count accepted by step_start. Larger counts are clamped to MAX_STEP.

Ports:
- clk  in  1  EBOX clock.
- reset  in  1  Asynchronous, active-high reset.
- sc_sel  in  2  SC load select: 00 hold, 01 SCAD, 10 AR shift field, 11 FE.
- fe_load  in  1  Load FE from scad this cycle.
- scad  in  W  SCAD adder result.
- ar_shift  in  W  Pre-formatted AR shift-count field, already sign-extended.
- step_start  in  1  Begin step loop; loads SC from scad.
- step_busy  out  1  Step loop active.
- step_done  out  1  One-cycle pulse when the loop terminates.
- sc  out  W  SC register.
- fe  out  W  FE register.
- sc_neg  out  1  Equals sc[0].
- sc_zero  out  1  sc == 0.
- sc_ge_36  out  1  ~sc[0] & |sc[1:3]. True for values 64..511.
- sc_36_to_63  out  1  ~sc[0] & ~|sc[1:3] & sc[4] & (sc[5]|sc[6]|sc[7]). True for values 36..63.

Behaviour:
- Reset (asynchronous, active-high):
  - sc=0, fe=0, step_busy=0, step_done=0.
  - Flags then read sc_zero=1 and all other flags 0.
  - Reset mid-loop aborts the loop with no done pulse.
- Flags are purely combinational from the sc register. They reach the shift matrix with zero added latency after the SC edge.
- SC update priority, evaluated on each rising clk:
  1. step_start: sc<=scad (clamped to MAX_STEP if scad is non-negative and above it); step_busy<=1. A negative scad gives a zero-iteration loop: step_busy stays 0 and step_done pulses the next cycle.
  2. Explicit load (sc_sel!=00) while busy: the load is performed, step_busy<=0, no step_done. This is an abort.
  3. busy with no load: sc<=sc-1 (W-bit two's complement). When the new value has sc[0]=1 (0 -> -1): step_busy<=0, step_done<=1 for exactly one cycle.
  4. Idle: sc_sel 01 -> scad; 10 -> ar_shift; 11 -> fe; 00 -> hold.
- Iteration count: loading N>=0 gives busy for N+1 cycles. step_done is asserted in the cycle immediately after busy drops, with sc=-1 (all ones).
- step_start while busy restarts the loop with the new count; no done pulse for the old loop.
- FE:
  - fe_load loads fe<=scad regardless of loop state.
  - sc_sel=11 with fe_load in the same cycle: SC receives the old fe. The FE and SC registers are parallel.
- Wrap: decrement from -512 is not reachable inside a loop, because termination occurs at -1. An idle sc holds its value indefinitely.
- All arithmetic is modulo 2^W. There are no saturation rules except the MAX_STEP clamp.

Optional Feature:
- SCD_SC_PAR_EN defined:
  - Adds an internal SC parity bit and output sc_par_err (1 bit).
  - The parity bit is recomputed as odd parity (^ of new value, inverted) on every SC write, including decrements.
  - sc_par_err = registered mismatch between stored parity and the recomputed parity of sc, sampled one cycle later. It is sticky until reset.
- Not defined: no parity bit; sc_par_err port absent.

Decomposition:
- Shared ebox package holds:
  - typedef sc_t (logic [0:9]);
  - enum sc_sel_e {SC_HOLD, SC_SCAD, SC_AR, SC_FE};
  - localparams SC_36=10'd36 and SC_64=10'd64.
- One natural sub-module, scd_sc_flags: purely combinational decode of sc into sc_neg, sc_zero, sc_ge_36 and sc_36_to_63. It is reused by the verification model.

Test Plan:
- Reset mid-loop: step_start with scad=5; assert reset in cycle 2 -> sc=0, busy=0, no step_done, sc_zero=1.
- Step loop: step_start scad=3 -> busy high for 4 cycles with sc 3,2,1,0; then sc=10'h3FF, step_done high 1 cycle, busy=0.
- Flag boundaries: load via sc_sel=01 with values 35, 36, 63, 64, 511, -1 -> (ge36, 36to63) = (0,0), (0,1), (0,1), (1,0), (1,0), (0,0); sc_neg=1 only for -1.
- Abort: step_start scad=10; on cycle 3 sc_sel=10 with ar_shift=7 -> sc=7, busy=0, no done pulse.
- FE/SC parallel: fe=20; same cycle fe_load scad=40 and sc_sel=11 -> sc=20, fe=40.
- Zero/negative count: step_start scad=0 -> busy 1 cycle then done. step_start scad=-2 -> busy never set, done pulses next cycle. With SCD_SC_PAR_EN, force the stored parity bit -> sc_par_err=1 and stays set.

Source files
------------

// File: rtl/scd_sc_fe_pkg.sv
// ============================================================================
// Module   : scd_sc_fe_pkg
// Purpose  : Shared EBOX definitions for the SC/FE register pair: the SC
//            value type, the SC load-select encoding and the flag thresholds.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package scd_sc_fe_pkg;

    // SC/FE value, big-endian bit numbering, bit 0 is the sign
    typedef logic [0:9] sc_t;

    // SC load-select encoding
    typedef enum logic [1:0] {
        SC_HOLD = 2'b00,
        SC_SCAD = 2'b01,
        SC_AR   = 2'b10,
        SC_FE   = 2'b11
    } sc_sel_e;

    // Lower bounds of the two shift-inhibit ranges
    localparam sc_t SC_36 = 10'd36;
    localparam sc_t SC_64 = 10'd64;

    // Odd parity of an SC value
    function automatic logic sc_odd_par(input sc_t v);
        return ~^v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scd_sc_flags.sv
// ============================================================================
// Module   : scd_sc_flags
// Purpose  : Combinational decode of the SC register into the sign, zero and
//            the two shift-inhibit range flags used by the SH mux.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scd_sc_flags
    import scd_sc_fe_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [0:W-1] sc,
    output logic         sc_neg,
    output logic         sc_zero,
    output logic         sc_ge_36,
    output logic         sc_36_to_63
);

    // Sign and zero come straight from the register bits
    assign sc_neg  = sc[0];
    assign sc_zero = ~|sc;

    // Bits 1:3 carry weights 256/128/64, so any of them set means 64..511
    assign sc_ge_36 = ~sc[0] & (|sc[1:3]);

    // Bit 4 is weight 32; bits 5:7 (16/8/4) lift the value to at least 36
    assign sc_36_to_63 = ~sc[0] & ~(|sc[1:3]) & sc[4] & (sc[5] | sc[6] | sc[7]);

endmodule

`default_nettype wire

// File: rtl/scd_sc_fe.sv
// ============================================================================
// Module   : scd_sc_fe
// Purpose  : Shift-count (SC) and floating-exponent (FE) register pair.
//            Supplies SC and its range flags to the shift matrix and runs
//            microcode step loops by counting SC down to -1.
//            Optional feature macro: SCD_SC_PAR_EN adds an SC parity bit and
//            the sticky sc_par_err output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scd_sc_fe
    import scd_sc_fe_pkg::*;
#(
    parameter int W        = 10,
    parameter int MAX_STEP = 511
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   sc_sel,
    input  logic         fe_load,
    input  logic [0:W-1] scad,
    input  logic [0:W-1] ar_shift,
    input  logic         step_start,
    output logic         step_busy,
    output logic         step_done,
    output logic [0:W-1] sc,
    output logic [0:W-1] fe,
    output logic         sc_neg,
    output logic         sc_zero,
    output logic         sc_ge_36,
    output logic         sc_36_to_63
`ifdef SCD_SC_PAR_EN
    ,
    output logic         sc_par_err
`endif
);

    localparam logic [0:W-1] C_MAX_STEP = MAX_STEP[W-1:0];
    localparam logic [0:W-1] C_ONE      = {{(W-1){1'b0}}, 1'b1};

    logic [0:W-1] r_sc;
    logic [0:W-1] r_fe;
    logic         r_busy;
    logic         r_done;

    logic [0:W-1] w_load_val;
    logic [0:W-1] w_sc_dec;
    logic [0:W-1] w_sc_next;
    logic         w_sc_we;
    logic         w_busy_next;
    logic         w_done_next;
    logic         w_scad_clamp;

    assign w_sc_dec     = r_sc - C_ONE;
    assign w_scad_clamp = ~scad[0] && (scad > C_MAX_STEP);

    // Source selected by sc_sel for an explicit SC load
    always_comb begin
        w_load_val = r_sc;
        case (sc_sel_e'(sc_sel))
            SC_SCAD: w_load_val = scad;
            SC_AR:   w_load_val = ar_shift;
            SC_FE:   w_load_val = r_fe;
            default: w_load_val = r_sc;
        endcase
    end

    // SC update priority: loop start, abort-by-load, countdown, idle load
    always_comb begin
        w_sc_next   = r_sc;
        w_sc_we     = 1'b0;
        w_busy_next = r_busy;
        w_done_next = 1'b0;
        if (step_start) begin
            // A negative count is a zero-iteration loop: done next cycle
            w_sc_we     = 1'b1;
            w_sc_next   = w_scad_clamp ? C_MAX_STEP : scad;
            w_busy_next = ~scad[0];
            w_done_next = scad[0];
        end else if (r_busy && (sc_sel != 2'b00)) begin
            w_sc_we     = 1'b1;
            w_sc_next   = w_load_val;
            w_busy_next = 1'b0;
        end else if (r_busy) begin
            w_sc_we   = 1'b1;
            w_sc_next = w_sc_dec;
            if (w_sc_dec[0]) begin
                w_busy_next = 1'b0;
                w_done_next = 1'b1;
            end
        end else if (sc_sel != 2'b00) begin
            w_sc_we   = 1'b1;
            w_sc_next = w_load_val;
        end
    end

    // SC, FE and loop-control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sc   <= '0;
            r_fe   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_sc_we) begin
                r_sc <= w_sc_next;
            end
            if (fe_load) begin
                r_fe <= scad;
            end
            r_busy <= w_busy_next;
            r_done <= w_done_next;
        end
    end

`ifdef SCD_SC_PAR_EN
    logic r_sc_par;
    logic r_par_err;

    // Parity tracks every SC write; the check runs one cycle behind
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sc_par  <= 1'b1;
            r_par_err <= 1'b0;
        end else begin
            if (w_sc_we) begin
                r_sc_par <= ~^w_sc_next;
            end
            r_par_err <= r_par_err | (r_sc_par != (~^r_sc));
        end
    end

    assign sc_par_err = r_par_err;
`endif

    assign sc        = r_sc;
    assign fe        = r_fe;
    assign step_busy = r_busy;
    assign step_done = r_done;

    scd_sc_flags #(
        .W (W)
    ) u_flags (
        .sc          (r_sc),
        .sc_neg      (sc_neg),
        .sc_zero     (sc_zero),
        .sc_ge_36    (sc_ge_36),
        .sc_36_to_63 (sc_36_to_63)
    );

endmodule

`default_nettype wire

// File: tb/tb_scd_sc_fe.sv
// ============================================================================
// Module   : tb_scd_sc_fe
// Purpose  : Self-checking bench for scd_sc_fe: flag boundary table, directed
//            loop/abort/FE sequences and randomized traffic against a
//            behavioural model. Honors SCD_SC_PAR_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scd_sc_fe;
    import scd_sc_fe_pkg::*;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   sc_sel;
    logic         fe_load;
    logic [0:W-1] scad;
    logic [0:W-1] ar_shift;
    logic         step_start;
    logic         step_busy;
    logic         step_done;
    logic [0:W-1] sc;
    logic [0:W-1] fe;
    logic         sc_neg;
    logic         sc_zero;
    logic         sc_ge_36;
    logic         sc_36_to_63;
`ifdef SCD_SC_PAR_EN
    logic         sc_par_err;
`endif

    scd_sc_fe #(.W(W), .MAX_STEP(511)) dut (
        .clk         (clk),
        .reset       (reset),
        .sc_sel      (sc_sel),
        .fe_load     (fe_load),
        .scad        (scad),
        .ar_shift    (ar_shift),
        .step_start  (step_start),
        .step_busy   (step_busy),
        .step_done   (step_done),
        .sc          (sc),
        .fe          (fe),
        .sc_neg      (sc_neg),
        .sc_zero     (sc_zero),
        .sc_ge_36    (sc_ge_36),
        .sc_36_to_63 (sc_36_to_63)
`ifdef SCD_SC_PAR_EN
        ,
        .sc_par_err  (sc_par_err)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: SC/FE as unsigned 0..1023 integers
    int m_sc, m_fe, m_busy, m_done;

    typedef struct {
        int val;
        bit ge36;
        bit r36;
        bit neg;
    } flag_vec_t;

    flag_vec_t fvec[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        sc_sel     = 2'b00;
        fe_load    = 1'b0;
        scad       = '0;
        ar_shift   = '0;
        step_start = 1'b0;
    endtask

    // Next reference state from the current inputs
    task automatic model_edge();
        int s, ld, nsc, nb, nd, nfe;
        s   = int'(scad);
        nsc = m_sc;
        nb  = m_busy;
        nd  = 0;
        nfe = fe_load ? s : m_fe;
        case (sc_sel)
            2'b01:   ld = s;
            2'b10:   ld = int'(ar_shift);
            2'b11:   ld = m_fe;
            default: ld = m_sc;
        endcase
        if (step_start) begin
            if (s >= 512) begin
                nsc = s; nb = 0; nd = 1;
            end else begin
                nsc = (s > 511) ? 511 : s; nb = 1;
            end
        end else if (m_busy != 0 && sc_sel != 2'b00) begin
            nsc = ld; nb = 0;
        end else if (m_busy != 0) begin
            nsc = (m_sc + 1023) % 1024;
            if (nsc >= 512) begin
                nb = 0; nd = 1;
            end
        end else if (sc_sel != 2'b00) begin
            nsc = ld;
        end
        m_sc = nsc; m_fe = nfe; m_busy = nb; m_done = nd;
    endtask

    task automatic model_reset();
        m_sc = 0; m_fe = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic compare_model();
        chk("sc",          32'(sc),        32'(m_sc));
        chk("fe",          32'(fe),        32'(m_fe));
        chk("step_busy",   32'(step_busy), 32'(m_busy));
        chk("step_done",   32'(step_done), 32'(m_done));
        chk("sc_neg",      32'(sc_neg),    32'(m_sc >= 512));
        chk("sc_zero",     32'(sc_zero),   32'(m_sc == 0));
        chk("sc_ge_36",    32'(sc_ge_36),  32'(m_sc >= int'(SC_64) && m_sc < 512));
        chk("sc_36_to_63", 32'(sc_36_to_63), 32'(m_sc >= int'(SC_36) && m_sc < int'(SC_64)));
    endtask

    // One clock: advance the model, clock the DUT, compare 1 time unit later
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        model_reset();
        chk("rst_sc",      32'(sc),        32'd0);
        chk("rst_busy",    32'(step_busy), 32'd0);
        chk("rst_done",    32'(step_done), 32'd0);
        chk("rst_sc_zero", 32'(sc_zero),   32'd1);
        compare_model();
        reset = 1'b0;
    endtask

    initial begin
        fvec[0] = '{35,   1'b0, 1'b0, 1'b0};
        fvec[1] = '{36,   1'b0, 1'b1, 1'b0};
        fvec[2] = '{63,   1'b0, 1'b1, 1'b0};
        fvec[3] = '{64,   1'b1, 1'b0, 1'b0};
        fvec[4] = '{511,  1'b1, 1'b0, 1'b0};
        fvec[5] = '{1023, 1'b0, 1'b0, 1'b1};

        idle_inputs();
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        pulse_reset();

        // Reset in the middle of a loop: no done pulse afterwards
        step_start = 1'b1; scad = 10'd5;
        cyc();
        idle_inputs();
        cyc();
        pulse_reset();
        cyc();
        chk("rstloop_done", 32'(step_done), 32'd0);
        chk("rstloop_sc",   32'(sc),        32'd0);

        // Step loop with count 3
        step_start = 1'b1; scad = 10'd3;
        cyc();
        idle_inputs();
        chk("loop_busy0", 32'(step_busy), 32'd1);
        chk("loop_sc0",   32'(sc),        32'd3);
        for (int v = 2; v >= 0; v--) begin
            cyc();
            chk("loop_busy", 32'(step_busy), 32'd1);
            chk("loop_sc",   32'(sc),        32'(v));
        end
        cyc();
        chk("loop_end_sc",   32'(sc),        32'h3FF);
        chk("loop_end_done", 32'(step_done), 32'd1);
        chk("loop_end_busy", 32'(step_busy), 32'd0);
        cyc();
        chk("loop_done_once", 32'(step_done), 32'd0);

        // Flag boundary table
        for (int i = 0; i < 6; i++) begin
            sc_sel = 2'b01; scad = 10'(fvec[i].val);
            cyc();
            chk("tbl_sc",    32'(sc),          32'(fvec[i].val));
            chk("tbl_ge36",  32'(sc_ge_36),    32'(fvec[i].ge36));
            chk("tbl_36_63", 32'(sc_36_to_63), 32'(fvec[i].r36));
            chk("tbl_neg",   32'(sc_neg),      32'(fvec[i].neg));
        end
        idle_inputs();

        // Abort a running loop with an AR load
        step_start = 1'b1; scad = 10'd10;
        cyc();
        idle_inputs();
        cyc();
        sc_sel = 2'b10; ar_shift = 10'd7;
        cyc();
        idle_inputs();
        chk("abort_sc",   32'(sc),        32'd7);
        chk("abort_busy", 32'(step_busy), 32'd0);
        chk("abort_done", 32'(step_done), 32'd0);
        cyc();
        chk("abort_done2", 32'(step_done), 32'd0);
        chk("abort_hold",  32'(sc),        32'd7);

        // FE and SC load in parallel: SC sees the old FE
        fe_load = 1'b1; scad = 10'd20;
        cyc();
        chk("fe_load", 32'(fe), 32'd20);
        fe_load = 1'b1; scad = 10'd40; sc_sel = 2'b11;
        cyc();
        idle_inputs();
        chk("par_sc", 32'(sc), 32'd20);
        chk("par_fe", 32'(fe), 32'd40);

        // Zero count: one busy cycle then done
        step_start = 1'b1; scad = 10'd0;
        cyc();
        idle_inputs();
        chk("zero_busy", 32'(step_busy), 32'd1);
        cyc();
        chk("zero_done", 32'(step_done), 32'd1);
        chk("zero_sc",   32'(sc),        32'h3FF);

        // Negative count: never busy, done right after
        step_start = 1'b1; scad = 10'h3FE;
        cyc();
        idle_inputs();
        chk("neg_busy", 32'(step_busy), 32'd0);
        chk("neg_done", 32'(step_done), 32'd1);
        cyc();
        chk("neg_done_once", 32'(step_done), 32'd0);
        chk("neg_hold",      32'(sc),        32'h3FE);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            step_start = ($urandom_range(0, 9) == 0);
            fe_load    = ($urandom_range(0, 4) == 0);
            sc_sel     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            scad       = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 1023))
                                                     : 10'($urandom_range(0, 12));
            ar_shift   = 10'($urandom_range(0, 1023));
            cyc();
`ifdef SCD_SC_PAR_EN
            chk("rand_par_err", 32'(sc_par_err), 32'd0);
`endif
        end
        idle_inputs();

`ifdef SCD_SC_PAR_EN
        begin
            logic p;
            chk("par_clean", 32'(sc_par_err), 32'd0);
            p = dut.r_sc_par;
            force dut.r_sc_par = ~p;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("par_err_set", 32'(sc_par_err), 32'd1);
            release dut.r_sc_par;
            sc_sel = 2'b01; scad = 10'd9;
            @(posedge clk); #1;
            idle_inputs();
            @(posedge clk); #1;
            chk("par_err_sticky", 32'(sc_par_err), 32'd1);
            reset = 1'b1; #2;
            chk("par_err_reset", 32'(sc_par_err), 32'd0);
            reset = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
